// File: rtl/vga_pkg.sv
// Definitions shared across the VGA display path: timing, pixel format
// and the framebuffer fetch state machine encoding.
package vga_pkg;

    localparam int HDISP  = 640;
    localparam int VDISP  = 480;
    localparam int HFP    = 16;
    localparam int HPULSE = 96;
    localparam int HBP    = 48;
    localparam int VFP    = 11;
    localparam int VPULSE = 2;
    localparam int VBP    = 31;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REQ,
        SETTLE
    } fetch_state_t;

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle used between the SDRAM controller and its masters.
interface wshb_if #(
    parameter int DATA_BYTES = 2,
    parameter int ADR_WIDTH  = 32
);
    logic [ADR_WIDTH-1:0]    adr;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic [DATA_BYTES-1:0]   sel;
    logic                    we;
    logic                    cyc;
    logic                    stb;
    logic                    ack;
    logic [2:0]              cti;
    logic [1:0]              bte;

    modport master (
        output adr, dat_ms, sel, we, cyc, stb, cti, bte,
        input  dat_sm, ack
    );

    modport slave (
        input  adr, dat_ms, sel, we, cyc, stb, cti, bte,
        output dat_sm, ack
    );
endinterface

// File: rtl/raster_addr_gen.sv
// Raster-order pixel position with a running byte address, so the
// framebuffer address never needs a multiply.
module raster_addr_gen #(
    parameter int                   HDISP     = 640,
    parameter int                   VDISP     = 480,
    parameter int                   ADR_WIDTH = 32,
    parameter logic [ADR_WIDTH-1:0] BASE_ADR  = '0,
    localparam int                  XW        = (HDISP > 1) ? $clog2(HDISP) : 1,
    localparam int                  YW        = (VDISP > 1) ? $clog2(VDISP) : 1
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic                 advance_i,
    input  logic                 reload_i,
    output logic [ADR_WIDTH-1:0] adr_o,
    output logic                 last_pixel_o
);

    localparam logic [XW-1:0]        X_LAST      = XW'(HDISP - 1);
    localparam logic [YW-1:0]        Y_LAST      = YW'(VDISP - 1);
    localparam logic [ADR_WIDTH-1:0] PIXEL_BYTES = ADR_WIDTH'(2);

    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [ADR_WIDTH-1:0] adr_q, adr_d;

    // Reload wins over advance: a resync discards the position being advanced.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        adr_d = adr_q;
        if (reload_i) begin
            x_d   = '0;
            y_d   = '0;
            adr_d = BASE_ADR;
        end else if (advance_i) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d   = '0;
                    adr_d = BASE_ADR;
                end else begin
                    y_d   = y_q + YW'(1);
                    adr_d = adr_q + PIXEL_BYTES;
                end
            end else begin
                x_d   = x_q + XW'(1);
                adr_d = adr_q + PIXEL_BYTES;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            x_q   <= '0;
            y_q   <= '0;
            adr_q <= BASE_ADR;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            adr_q <= adr_d;
        end
    end

    assign adr_o        = adr_q;
    assign last_pixel_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/vga_frame_fetch.sv
// Wishbone master streaming the RGB565 framebuffer in raster order into the
// display FIFO, one outstanding read at a time.
module vga_frame_fetch #(
    parameter int          HDISP      = vga_pkg::HDISP,
    parameter int          VDISP      = vga_pkg::VDISP,
    parameter logic [31:0] BASE_ADR   = 32'h0,
    parameter int          DATA_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  resync,
    wshb_if.master                wshb_ifm,
    output logic                  fifo_write,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    input  logic                  fifo_wfull,
    output logic                  frame_done,
    output logic                  busy
);

    import vga_pkg::*;

    fetch_state_t          state_q;
    logic                  stb_q;
    logic                  resync_pend_q;
    logic                  fifo_write_q;
    logic [DATA_WIDTH-1:0] fifo_wdata_q;
    logic                  frame_done_q;

    logic        ack_accept;
    logic        advance;
    logic        reload;
    logic        last_pixel;
    logic [31:0] adr;

    // stb is always high in REQ, so a stray ack outside REQ never counts.
    assign ack_accept = (state_q == REQ) && wshb_ifm.ack;
    assign advance    = ack_accept && !resync_pend_q;
    assign reload     = resync_pend_q && (ack_accept || (state_q == IDLE));

    raster_addr_gen #(
        .HDISP     (HDISP),
        .VDISP     (VDISP),
        .ADR_WIDTH (32),
        .BASE_ADR  (BASE_ADR)
    ) u_addr_gen (
        .clk_i        (CLK),
        .srst_i       (rst),
        .advance_i    (advance),
        .reload_i     (reload),
        .adr_o        (adr),
        .last_pixel_o (last_pixel)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q       <= IDLE;
            stb_q         <= 1'b0;
            resync_pend_q <= 1'b0;
            fifo_write_q  <= 1'b0;
            fifo_wdata_q  <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            fifo_write_q <= 1'b0;
            frame_done_q <= 1'b0;
            // A new resync request must survive the clear of an older one.
            if (reload) resync_pend_q <= 1'b0;
            if (resync) resync_pend_q <= 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (enable && !resync_pend_q) state_q <= CHECK;
                end
                CHECK: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (!fifo_wfull) begin
                        stb_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (wshb_ifm.ack) begin
                        stb_q <= 1'b0;
                        if (!resync_pend_q) begin
                            fifo_write_q <= 1'b1;
                            fifo_wdata_q <= DATA_WIDTH'(wshb_ifm.dat_sm);
                            frame_done_q <= last_pixel;
                        end
                        state_q <= SETTLE;
                    end
                end
                SETTLE: state_q <= CHECK;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wshb_ifm.adr    = adr;
    assign wshb_ifm.dat_ms = '0;
    assign wshb_ifm.sel    = '1;
    assign wshb_ifm.we     = 1'b0;
    assign wshb_ifm.cti    = '0;
    assign wshb_ifm.bte    = '0;
    assign wshb_ifm.cyc    = stb_q;
    assign wshb_ifm.stb    = stb_q;

    assign busy       = stb_q;
    assign fifo_write = fifo_write_q;
    assign fifo_wdata = fifo_wdata_q;
    assign frame_done = frame_done_q;

    // The fetcher is the FIFO's only writer and checks full before each read.
    a_no_write_when_full: assert property (@(posedge CLK) disable iff (rst)
        !(fifo_write_q && fifo_wfull));

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Bench for vga_frame_fetch: Wishbone slave with variable latency, FIFO
// occupancy model and a raster-order pixel model checked every cycle.
module tb_vga_frame_fetch;

    localparam int          HDISP  = 4;
    localparam int          VDISP  = 2;
    localparam int          NPIX   = HDISP * VDISP;
    localparam logic [31:0] BASE   = 32'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        resync;
    logic        fifo_write;
    logic [15:0] fifo_wdata;
    logic        fifo_wfull;
    logic        frame_done;
    logic        busy;

    int          lat;
    logic        stray;
    int          depth;
    logic        rd_en;
    int          wait_cnt = 0;
    int          fcount = 0;
    logic [15:0] slave_data = 16'h1234;

    int checks = 0;
    int failures = 0;

    // Model and logs (written only by the monitor process)
    bit          mon_on = 0;
    int          p = 0;
    bit          pend = 0;
    bit          exp_wr = 0;
    bit          exp_fd = 0;
    logic [15:0] exp_data = '0;
    int          wr_cnt = 0;
    int          fd_cnt = 0;
    int          fd_at_write = -1;
    int          stb_hi = 0;
    int          cyc_n = 0;
    bit          prev_stb = 0;
    logic [31:0] hs_q[$];
    int          rise_q[$];

    wshb_if #(.DATA_BYTES(2), .ADR_WIDTH(32)) wb();

    vga_frame_fetch #(
        .HDISP(HDISP), .VDISP(VDISP), .BASE_ADR(BASE), .DATA_WIDTH(16)
    ) dut (
        .CLK(clk), .rst(rst), .enable(enable), .resync(resync),
        .wshb_ifm(wb),
        .fifo_write(fifo_write), .fifo_wdata(fifo_wdata), .fifo_wfull(fifo_wfull),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Slave: ack once stb has waited lat cycles (lat=0 acks in the stb cycle)
    assign wb.ack    = (wb.stb && (wait_cnt >= lat)) || stray;
    assign wb.dat_sm = slave_data;

    always @(posedge clk) begin
        if (wb.stb && !wb.ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (wb.stb && wb.ack) slave_data <= 16'($urandom);
    end

    assign fifo_wfull = (fcount >= depth);
    always @(posedge clk) begin
        if (rst) fcount <= 0;
        else fcount <= fcount + (fifo_write ? 1 : 0) - ((rd_en && fcount > 0) ? 1 : 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; resync = 1'b0; stray = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Every-cycle comparison against the raster model
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mon_on) begin
                cyc_n++;
                chk("fifo_write", fifo_write, exp_wr);
                if (exp_wr) chk("fifo_wdata", fifo_wdata, exp_data);
                chk("frame_done", frame_done, exp_fd);
                chk("busy_vs_stb", busy, wb.stb);
                chk("cyc_vs_stb", wb.cyc, wb.stb);
                chk("const_outputs", {wb.we, wb.sel, wb.cti, wb.bte, wb.dat_ms},
                    {1'b0, 2'b11, 3'b000, 2'b00, 16'h0000});
                if (wb.stb) chk("adr", wb.adr, BASE + 32'(2 * p));
                if (fifo_write) begin
                    chk("write_while_full", fifo_wfull, 1'b0);
                    wr_cnt++;
                    if (frame_done) fd_at_write = wr_cnt;
                end
                if (frame_done) fd_cnt++;
                if (wb.stb) stb_hi++;
                if (wb.stb && !prev_stb) rise_q.push_back(cyc_n);
                prev_stb = wb.stb;

                exp_wr = 0;
                exp_fd = 0;
                if (rst) begin
                    p = 0;
                    pend = 0;
                end else begin
                    if (wb.stb && wb.ack) begin
                        hs_q.push_back(wb.adr);
                        if (!pend) begin
                            exp_wr   = 1;
                            exp_data = wb.dat_sm;
                            exp_fd   = (p == NPIX - 1);
                            p        = (p == NPIX - 1) ? 0 : p + 1;
                        end else begin
                            p    = 0;
                            pend = 0;
                        end
                    end
                    if (resync) pend = 1;
                end
            end
        end
    endtask

    initial begin
        int hb, wb0, fb, sb, rb;
        rst = 1'b1; enable = 1'b0; resync = 1'b0; stray = 1'b0;
        lat = 2; depth = 100; rd_en = 1'b1;
        fork
            monitor();
        join_none
        tick(); tick();
        mon_on = 1;

        // 1: full frame, FIFO never full
        do_reset();
        chk("rst_fifo_write", fifo_write, 1'b0);
        chk("rst_fifo_wdata", fifo_wdata, 16'h0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_stb", wb.stb, 1'b0);
        chk("rst_adr", wb.adr, BASE);
        hb = hs_q.size(); wb0 = wr_cnt; fb = fd_cnt;
        enable = 1'b1;
        for (int c = 0; c < 300 && hs_q.size() < hb + 9; c++) tick();
        chk("t1_handshakes_seen", hs_q.size() >= hb + 9, 1'b1);
        if (hs_q.size() >= hb + 9)
            for (int i = 0; i < 9; i++) chk("t1_adr_seq", hs_q[hb + i], BASE + 32'(2 * (i % 8)));
        chk("t1_writes", wr_cnt - wb0, 8);
        chk("t1_frame_done_count", fd_cnt - fb, 1);
        chk("t1_frame_done_on_write8", fd_at_write - wb0, 8);

        // 2: FIFO fills after 3 pixels
        do_reset();
        depth = 3; rd_en = 1'b0; lat = 2;
        wb0 = wr_cnt;
        enable = 1'b1;
        for (int c = 0; c < 200 && wr_cnt - wb0 < 3; c++) tick();
        chk("t2_three_writes", wr_cnt - wb0, 3);
        sb = stb_hi;
        repeat (10) tick();
        chk("t2_stb_held_low", stb_hi - sb, 0);
        chk("t2_adr_held", wb.adr, 32'h106);
        hb = hs_q.size();
        rd_en = 1'b1;
        for (int c = 0; c < 100 && hs_q.size() <= hb; c++) tick();
        chk("t2_resume_seen", hs_q.size() > hb, 1'b1);
        if (hs_q.size() > hb) chk("t2_resume_adr", hs_q[hb], 32'h106);

        // 3: resync while the 0x104 read is in flight
        do_reset();
        depth = 100; rd_en = 1'b1; lat = 2;
        wb0 = wr_cnt;
        enable = 1'b1;
        for (int c = 0; c < 200 && !(wb.stb && wb.adr == 32'h104); c++) tick();
        chk("t3_reached_104", wb.stb && wb.adr == 32'h104, 1'b1);
        hb = hs_q.size();
        resync = 1'b1; tick(); resync = 1'b0;
        for (int c = 0; c < 100 && hs_q.size() < hb + 2; c++) tick();
        chk("t3_handshakes_seen", hs_q.size() >= hb + 2, 1'b1);
        if (hs_q.size() >= hb + 2) begin
            chk("t3_dropped_adr", hs_q[hb], 32'h104);
            chk("t3_restart_adr", hs_q[hb + 1], 32'h100);
        end
        chk("t3_writes", wr_cnt - wb0, 2);

        // 4: enable dropped during a 5-cycle read
        do_reset();
        lat = 5;
        wb0 = wr_cnt; hb = hs_q.size();
        enable = 1'b1;
        for (int c = 0; c < 50 && !wb.stb; c++) tick();
        chk("t4_stb_seen", wb.stb, 1'b1);
        sb = stb_hi;
        enable = 1'b0;
        repeat (30) tick();
        chk("t4_writes", wr_cnt - wb0, 1);
        chk("t4_handshakes", hs_q.size() - hb, 1);
        chk("t4_stb_cycles", stb_hi - sb, 6);
        chk("t4_idle_stb", wb.stb, 1'b0);

        // 5: reset mid-read, stray ack one cycle later
        enable = 1'b1;
        for (int c = 0; c < 50 && !wb.stb; c++) tick();
        chk("t5_stb_seen", wb.stb, 1'b1);
        tick();
        wb0 = wr_cnt;
        rst = 1'b1; enable = 1'b0; tick();
        rst = 1'b0; stray = 1'b1; tick();
        stray = 1'b0;
        chk("t5_fifo_write", fifo_write, 1'b0);
        chk("t5_frame_done", frame_done, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_stb", wb.stb, 1'b0);
        chk("t5_adr", wb.adr, BASE);
        repeat (3) tick();
        chk("t5_no_write", wr_cnt - wb0, 0);
        hb = hs_q.size();
        enable = 1'b1;
        for (int c = 0; c < 50 && hs_q.size() <= hb; c++) tick();
        chk("t5_restart_seen", hs_q.size() > hb, 1'b1);
        if (hs_q.size() > hb) chk("t5_restart_adr", hs_q[hb], 32'h100);

        // 6: zero-wait slave
        do_reset();
        lat = 0;
        rb = rise_q.size(); hb = hs_q.size(); wb0 = wr_cnt;
        enable = 1'b1;
        for (int c = 0; c < 100 && rise_q.size() < rb + 5; c++) tick();
        enable = 1'b0;
        repeat (10) tick();
        chk("t6_rises_seen", rise_q.size() >= rb + 5, 1'b1);
        if (rise_q.size() >= rb + 5)
            for (int i = 0; i < 4; i++) chk("t6_stb_spacing", rise_q[rb + i + 1] - rise_q[rb + i], 3);
        chk("t6_one_write_per_txn", wr_cnt - wb0, hs_q.size() - hb);

        // 7: randomized latency, FIFO drain, resync and stray acks
        do_reset();
        depth = 4; lat = 2;
        wb0 = wr_cnt; fb = fd_cnt;
        enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!wb.stb) lat = $urandom_range(0, 4);
            rd_en  = 1'($urandom_range(0, 1));
            resync = (c > 4) && ($urandom_range(0, 39) == 0);
            stray  = !wb.stb && ($urandom_range(0, 9) == 0);
            tick();
        end
        resync = 1'b0; stray = 1'b0; enable = 1'b0;
        repeat (10) tick();
        chk("t7_progress", (wr_cnt - wb0) > 100, 1'b1);
        chk("t7_frames", (fd_cnt - fb) > 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
